mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the CPU data port, downstream of the core's
//  mem_addr/mem_din/mem_w/mem_r outputs. Buffers stored bytes in a FIFO and

---
 rtl/mmio_uart_tx_if.sv | 10 +
 rtl/mmio_uart_tx.sv | 101 ++++++++++
 tb/tb_mmio_uart_tx.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// mmio_uart_tx_if: CPU data-port bundle (address, store data, lane enables, read data)
interface mmio_uart_tx_if #(parameter int XLEN = 32);
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_din;
  logic [XLEN-1:0] rdata;
  logic [XLEN/8-1:0] mem_w;
  logic [XLEN/8-1:0] mem_r;
  modport master(output mem_addr, mem_din, mem_w, mem_r, input rdata);
  modport slave(input mem_addr, mem_din, mem_w, mem_r, output rdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO and same-cycle register reads
module mmio_uart_tx #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] BASE = 32'h10000000,
  parameter int FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input logic clk,
  input logic rst,
  mmio_uart_tx_if.slave bus,
  output logic tx,
  output logic irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [7:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic [15:0] div, bcnt, bcnt_n;
  logic [2:0] bidx, bidx_n;
  logic [7:0] shift, shift_n;
  logic [1:0] rsel;
  logic hit, full, empty, busy, push_req, push, pop, ovf, tx_n, unused_bits;
  assign hit = bus.mem_addr[XLEN-1:4] == BASE[XLEN-1:4];
  assign rsel = bus.mem_addr[3:2];
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign busy = state != IDLE;
  assign irq = !full;
  assign pop = state == IDLE && !empty;
  assign push_req = hit && rsel == 2'd0 && bus.mem_w[0];
  // a full FIFO still accepts when the FSM frees a slot on the same edge
  assign push = push_req && (!full || pop);
  assign bus.rdata = !(hit && |bus.mem_r) ? '0 :
                     rsel == 2'd1 ? XLEN'({ovf, busy, empty, full}) :
                     rsel == 2'd2 ? XLEN'(div) : '0;
  assign unused_bits = &{bus.mem_addr[1:0], bus.mem_din[XLEN-1:16], bus.mem_w[XLEN/8-1:2]};
  always_comb begin
    state_n = state;
    bcnt_n = bcnt == '0 ? div : bcnt - 16'd1;
    bidx_n = bidx;
    shift_n = shift;
    tx_n = 1'b1;
    case (state)
      IDLE: begin
        bcnt_n = div;
        if (!empty) begin
          state_n = START;
          shift_n = fifo[rp];
        end
      end
      START: begin
        tx_n = 1'b0;
        if (bcnt == '0) begin
          state_n = DATA;
          bidx_n = '0;
        end
      end
      DATA: begin
        tx_n = shift[0];
        if (bcnt == '0) begin
          state_n = bidx == 3'd7 ? STOP : DATA;
          bidx_n = bidx + 3'd1;
          shift_n = shift >> 1;
        end
      end
      default: state_n = bcnt == '0 ? IDLE : STOP;
    endcase
  end
  // tx is registered, so the line lags the state by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      count <= '0;
      ovf <= 1'b0;
      div <= DIV_RESET;
      bcnt <= '0;
      bidx <= '0;
      shift <= '0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      bcnt <= bcnt_n;
      bidx <= bidx_n;
      shift <= shift_n;
      tx <= tx_n;
      wp <= push ? wp + AW'(1) : wp;
      rp <= pop ? rp + AW'(1) : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      ovf <= (push_req && !push) ? 1'b1 : (hit && rsel == 2'd1 && |bus.mem_w) ? 1'b0 : ovf;
      if (hit && rsel == 2'd2 && bus.mem_w[0] && bus.mem_w[1])
        div <= bus.mem_din[15:0];
    end
  end
  always_ff @(posedge clk)
    if (push)
      fifo[wp] <= bus.mem_din[7:0];
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: register vectors, directed frame-timing sequences and random traffic vs a frame-schedule model
module tb_mmio_uart_tx;
  logic clk = 1'b0, rst = 1'b1, tx, irq;
  mmio_uart_tx_if #(.XLEN(32)) bus();
  mmio_uart_tx #(.XLEN(32)) dut(.clk(clk), .rst(rst), .bus(bus), .tx(tx), .irq(irq));
  always #5 clk = ~clk;
  localparam logic [31:0] A_TX = 32'h10000000, A_ST = 32'h10000004, A_DIV = 32'h10000008, A_R3 = 32'h1000000C;
  typedef struct { logic [31:0] a, d; logic [3:0] w, r; logic [31:0] exp; } vec_t;
  vec_t tv[$];
  int errs = 0, checks = 0, cyc = 0, md = 433;
  bit movf = 0;
  int pe[$], ps[$];
  logic [7:0] pb[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w, input logic [3:0] r);
    bus.mem_addr = a;
    bus.mem_din = d;
    bus.mem_w = w;
    bus.mem_r = r;
  endtask
  // Model: each accepted byte k gets a pop edge ps[k]; the frame occupies 10 bit periods after it
  function automatic logic m_tx(input int e);
    foreach (ps[k]) begin
      int o, b;
      o = e - ps[k] - 1;
      if (o >= 0 && o < 10 * (md + 1)) begin
        b = o / (md + 1);
        return b == 0 ? 1'b0 : b == 9 ? 1'b1 : pb[k][b-1];
      end
    end
    return 1'b1;
  endfunction
  function automatic bit m_busy(input int e);
    foreach (ps[k]) if (ps[k] <= e && e < ps[k] + 10 * (md + 1)) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int m_cnt(input int e);
    int n = 0;
    foreach (pe[k]) if (pe[k] <= e) n++;
    foreach (ps[k]) if (ps[k] <= e) n--;
    return n;
  endfunction
  function automatic void m_push(input logic [7:0] b);
    int e = cyc + 1;
    bit pop_here = 0;
    foreach (ps[k]) if (ps[k] == e) pop_here = 1;
    if (m_cnt(e - 1) < 4 || pop_here) begin
      ps.push_back(ps.size() == 0 ? e + 1 : (e + 1 > ps[$] + 10 * (md + 1) + 1 ? e + 1 : ps[$] + 10 * (md + 1) + 1));
      pe.push_back(e);
      pb.push_back(b);
    end else movf = 1;
  endfunction
  task automatic step(input bit p, input logic [7:0] b);
    drive(A_ST, 0, 4'h0, 4'hF);
    #1;
    chk("tx", tx, m_tx(cyc));
    chk("status", bus.rdata, {28'd0, movf, m_busy(cyc), m_cnt(cyc) == 0, m_cnt(cyc) == 4});
    chk("irq", irq, m_cnt(cyc) != 4);
    if (p) begin
      drive(A_TX, {24'd0, b}, 4'h1, 4'h0);
      m_push(b);
    end
    tick();
  endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] w);
    drive(a, d, w, 4'h0);
    if (a == A_ST && |w) movf = 0;
    if (a == A_DIV && w[1:0] == 2'b11) md = int'(d[15:0]);
    tick();
    drive(A_ST, 0, 4'h0, 4'hF);
  endtask
  task automatic do_reset();
    drive(A_ST, 0, 4'h0, 4'hF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pe.delete();
    ps.delete();
    pb.delete();
    movf = 0;
    md = 433;
  endtask
  initial begin
    logic [7:0] rx, byte_t4;
    logic txw [64];
    int bcount, lows, s, off, d, gap, first_low;
    tv.push_back('{A_ST, 0, 4'h0, 4'hF, 32'h2});
    tv.push_back('{A_DIV, 0, 4'h0, 4'hF, 32'd433});
    tv.push_back('{A_R3, 0, 4'h0, 4'hF, 0});
    tv.push_back('{A_ST, 0, 4'h0, 4'h0, 0});
    tv.push_back('{A_TX, 0, 4'h0, 4'hF, 0});
    tv.push_back('{32'h20000004, 0, 4'h0, 4'hF, 0});
    tv.push_back('{32'h20000000, 32'hAA, 4'hF, 4'hF, 0});
    tv.push_back('{A_TX, 32'h11, 4'h2, 4'h0, 0});
    tv.push_back('{A_ST, 0, 4'h0, 4'h1, 32'h2});
    tv.push_back('{A_DIV, 32'h7, 4'h1, 4'h0, 0});
    tv.push_back('{A_DIV, 0, 4'h0, 4'hF, 32'd433});
    tv.push_back('{A_DIV, 32'hFFFF0009, 4'h3, 4'h0, 0});
    tv.push_back('{A_DIV, 0, 4'h0, 4'h1, 32'd9});
    tv.push_back('{A_R3, 32'h5, 4'hF, 4'hF, 0});
    tv.push_back('{A_DIV, 0, 4'h0, 4'h2, 32'd9});
    tv.push_back('{32'h10000018, 0, 4'h0, 4'hF, 0});
    tv.push_back('{32'h1000000A, 0, 4'h0, 4'hF, 32'd9});
    tv.push_back('{A_DIV, 32'h12345, 4'hF, 4'h0, 0});
    tv.push_back('{A_DIV, 0, 4'h0, 4'hF, 32'h2345});
    tv.push_back('{A_ST, 0, 4'h0, 4'hF, 32'h2});
    do_reset();
    do_reset();
    chk("reset_tx", tx, 1'b1);
    chk("reset_irq", irq, 1'b1);
    foreach (tv[i]) begin
      drive(tv[i].a, tv[i].d, tv[i].w, tv[i].r);
      #1;
      chk($sformatf("vec%0d", i), bus.rdata, tv[i].exp);
      tick();
    end
    // T1: one 0x55 frame at DIV=3, decoded from the line like a receiver would
    do_reset();
    wr(A_DIV, 3, 4'h3);
    drive(A_TX, 32'h55, 4'h1, 4'h0);
    tick();
    drive(A_ST, 0, 4'h0, 4'hF);
    bcount = 0;
    first_low = -1;
    for (int i = 1; i < 60; i++) begin
      tick();
      txw[i] = tx;
      if (bus.rdata[2]) bcount++;
      if (first_low < 0 && tx == 1'b0) first_low = i;
    end
    for (int k = 0; k < 8; k++) rx[k] = txw[2 + 4 * (k + 1) + 2];
    chk("t1_start_offset", first_low, 2);
    chk("t1_start_bit", txw[4], 1'b0);
    chk("t1_byte", rx, 8'h55);
    chk("t1_stop_bit", txw[40], 1'b1);
    chk("t1_busy_clocks", bcount, 40);
    // T2/T3: DIV=0 back-to-back pushes overflow the FIFO; a STATUS write clears ovf
    do_reset();
    wr(A_DIV, 0, 4'h3);
    for (int i = 1; i <= 6; i++) step(1, 8'(i));
    for (int i = 0; i < 80; i++) step(0, 0);
    drive(A_ST, 0, 4'h0, 4'hF);
    #1;
    chk("t2_ovf_after_drain", bus.rdata, 32'hA);
    wr(A_ST, 0, 4'h1);
    #1;
    chk("t3_ovf_cleared", bus.rdata, 32'h2);
    step(0, 0);
    // T4: DIV 3->7 written during data bit 2; bit 2 keeps 4 clocks, later bits take 8
    do_reset();
    wr(A_DIV, 3, 4'h3);
    byte_t4 = 8'hA5;
    drive(A_TX, {24'd0, byte_t4}, 4'h1, 4'h0);
    tick();
    s = cyc + 1;
    drive(A_ST, 0, 4'h0, 4'hF);
    for (int i = 0; i < 80; i++) begin
      logic e;
      if (cyc == s + 13) drive(A_DIV, 7, 4'h3, 4'h0);
      else drive(A_ST, 0, 4'h0, 4'hF);
      tick();
      off = cyc - (s + 1);
      e = 1'b1;
      for (int k = 0; k < 10; k++) begin
        if (off >= 0 && off < (k <= 3 ? 4 : 8)) e = k == 0 ? 1'b0 : k == 9 ? 1'b1 : byte_t4[k-1];
        off -= k <= 3 ? 4 : 8;
      end
      chk("t4_tx", tx, e);
    end
    // T5: reset during data bit 4 with bytes still queued and ovf set
    do_reset();
    wr(A_DIV, 3, 4'h3);
    for (int i = 0; i < 6; i++) step(1, 8'h3C);
    while (cyc < ps[0] + 1 + 5 * 4 + 1) step(0, 0);
    do_reset();
    #1;
    chk("t5_tx", tx, 1'b1);
    chk("t5_status", bus.rdata, 32'h2);
    drive(A_DIV, 0, 4'h0, 4'hF);
    #1;
    chk("t5_div", bus.rdata, 32'd433);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx !== 1'b1) lows++;
    end
    chk("t5_no_frame_after_reset", lows, 0);
    // Random traffic against the frame-schedule model
    for (int run = 0; run < 3; run++) begin
      do_reset();
      d = $urandom_range(0, 2);
      wr(A_DIV, d, 4'h3);
      for (int n = 0; n < 25; n++) begin
        gap = $urandom_range(0, 12 * (d + 1));
        for (int g = 0; g < gap; g++) step(0, 0);
        step(1, 8'($urandom));
      end
      while (cyc < ps[$] + 10 * (md + 1) + 3) step(0, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
